// File: rtl/change_dispenser_pkg.sv
// Shared coin-dispenser definitions: denomination indices, unit values, FSM encoding
// and the greedy largest-first selector.
package change_dispenser_pkg;

  localparam int AMT_W_DEF      = 4;
  localparam int MAX_AMOUNT_DEF = 10;
  localparam int STOCK_W_DEF    = 4;
  localparam int INIT_STOCK_DEF = 8;

  localparam int D1000 = 3;
  localparam int D500  = 2;
  localparam int D200  = 1;
  localparam int D100  = 0;

  localparam int V1000 = 10;
  localparam int V500  = 5;
  localparam int V200  = 2;
  localparam int V100  = 1;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_PICK  = 3'd1,
    ST_OFFER = 3'd2,
    ST_DONE  = 3'd3,
    ST_FAIL  = 3'd4
  } state_t;

  // Highest set candidate wins; result is one-hot or zero.
  function automatic logic [3:0] greedy_pick(input logic [3:0] cand);
    logic [3:0] sel;
    sel = 4'b0000;
    if (cand[D1000])      sel[D1000] = 1'b1;
    else if (cand[D500])  sel[D500]  = 1'b1;
    else if (cand[D200])  sel[D200]  = 1'b1;
    else if (cand[D100])  sel[D100]  = 1'b1;
    return sel;
  endfunction

endpackage

// File: rtl/change_dispenser_if.sv
// Request, hopper handshake and status bundle between the vending FSM/hopper side
// (master) and the change dispenser (slave).
interface change_dispenser_if #(
  parameter int AMT_W = 4
);
  logic             start;
  logic [AMT_W-1:0] amount;
  logic [3:0]       refill;
  logic             coin_ready;
  logic             coin_valid;
  logic [3:0]       coin_sel;
  logic             busy;
  logic             done;
  logic             short_fail;
  logic [AMT_W-1:0] remaining;
  logic [3:0]       stock_empty;

  modport master (
    output start, amount, refill, coin_ready,
    input  coin_valid, coin_sel, busy, done, short_fail, remaining, stock_empty
  );

  modport slave (
    input  start, amount, refill, coin_ready,
    output coin_valid, coin_sel, busy, done, short_fail, remaining, stock_empty
  );
endinterface

// File: rtl/change_dispenser_stock_counter.sv
// Per-denomination coin stock: +1 on refill, -1 on dispense, saturating both ways,
// with an empty flag.
module change_dispenser_stock_counter #(
  parameter int STOCK_W = 4,
  parameter int INIT    = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               inc,
  input  logic               dec,
  output logic [STOCK_W-1:0] count,
  output logic               empty
);

  localparam logic [STOCK_W-1:0] MAX_VAL  = '1;
  localparam logic [STOCK_W-1:0] INIT_VAL = STOCK_W'(INIT);

  // Simultaneous inc and dec cancel, so a refill during a dispense nets to zero.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= INIT_VAL;
    end else if (inc && !dec) begin
      if (count != MAX_VAL) count <= count + STOCK_W'(1);
    end else if (dec && !inc) begin
      if (count != '0) count <= count - STOCK_W'(1);
    end
  end

  assign empty = (count == '0);

endmodule

// File: rtl/change_dispenser.sv
// Change dispenser: pays a balance as coins through the hopper handshake, one coin per
// handshake, greedy largest-first with per-denomination stock.
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   ST_IDLE  | waiting for start; validates and latches amount
//   ST_PICK  | choose largest coin that fits remaining and is in stock
//   ST_OFFER | coin offered to hopper, held until coin_ready
//   ST_DONE  | one-cycle done pulse, amount fully paid
//   ST_FAIL  | one-cycle short_fail pulse, remainder unpayable or rejected
module change_dispenser
  import change_dispenser_pkg::*;
#(
  parameter int AMT_W      = AMT_W_DEF,
  parameter int MAX_AMOUNT = MAX_AMOUNT_DEF,
  parameter int STOCK_W    = STOCK_W_DEF,
  parameter int INIT_STOCK = INIT_STOCK_DEF
) (
  input  logic               clk,
  input  logic               reset,
  change_dispenser_if.slave  bus
);

  state_t           state_q, state_d;
  logic [3:0]       sel_q, sel_d;
  logic [AMT_W-1:0] rem_q, rem_d;
  logic [AMT_W-1:0] sel_value;
  logic [3:0]       dec;
  logic [3:0]       empty;
  logic [3:0]       fits;
  logic [3:0]       in_stock;
  logic [3:0]       pick;
  logic [STOCK_W-1:0] stock [4];

  for (genvar d = 0; d < 4; d++) begin : g_stock
    change_dispenser_stock_counter #(
      .STOCK_W (STOCK_W),
      .INIT    (INIT_STOCK)
    ) u_cnt (
      .clk   (clk),
      .reset (reset),
      .inc   (bus.refill[d]),
      .dec   (dec[d]),
      .count (stock[d]),
      .empty (empty[d])
    );
    assign in_stock[d] = (stock[d] != '0);
  end

  assign fits[D1000] = (int'(rem_q) >= V1000);
  assign fits[D500]  = (int'(rem_q) >= V500);
  assign fits[D200]  = (int'(rem_q) >= V200);
  assign fits[D100]  = (int'(rem_q) >= V100);
  assign pick        = greedy_pick(fits & in_stock);

  always_comb begin
    sel_value = '0;
    case (sel_q)
      4'b1000: sel_value = AMT_W'(V1000);
      4'b0100: sel_value = AMT_W'(V500);
      4'b0010: sel_value = AMT_W'(V200);
      4'b0001: sel_value = AMT_W'(V100);
      default: sel_value = '0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      sel_q   <= '0;
      rem_q   <= '0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      rem_q   <= rem_d;
    end
  end

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    rem_d   = rem_q;
    dec     = '0;
    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          if (bus.amount == '0) begin
            rem_d   = '0;
            state_d = ST_DONE;
          end else if (int'(bus.amount) > MAX_AMOUNT) begin
            state_d = ST_FAIL;
          end else begin
            rem_d   = bus.amount;
            state_d = ST_PICK;
          end
        end
      end
      ST_PICK: begin
        if (pick != '0) begin
          sel_d   = pick;
          state_d = ST_OFFER;
        end else begin
          state_d = ST_FAIL;
        end
      end
      ST_OFFER: begin
        // PICK guaranteed sel_value <= rem_q, so this cannot underflow.
        if (bus.coin_ready) begin
          dec     = sel_q;
          rem_d   = rem_q - sel_value;
          state_d = (rem_d == '0) ? ST_DONE : ST_PICK;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      ST_FAIL: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  assign bus.coin_valid  = (state_q == ST_OFFER);
  assign bus.coin_sel    = (state_q == ST_OFFER) ? sel_q : 4'b0000;
  assign bus.busy        = (state_q != ST_IDLE);
  assign bus.done        = (state_q == ST_DONE);
  assign bus.short_fail  = (state_q == ST_FAIL);
  assign bus.remaining   = rem_q;
  assign bus.stock_empty = empty;

endmodule

// File: tb/tb_change_dispenser.sv
// Directed bench for change_dispenser: coin sequences, stalls, shortfall, rejects,
// refill collisions/saturation and mid-offer reset.
module tb_change_dispenser;

  logic clk;
  logic reset;

  change_dispenser_if #(.AMT_W(4)) bus ();

  change_dispenser dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  logic [3:0] coins [$];
  logic       saw_done;
  logic       saw_fail;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issues one request and collects every handshaken coin until done/short_fail.
  task automatic pay(input logic [3:0] amt);
    coins.delete();
    saw_done = 1'b0;
    saw_fail = 1'b0;
    bus.start  = 1'b1;
    bus.amount = amt;
    tick();
    bus.start = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (bus.coin_valid && bus.coin_ready) coins.push_back(bus.coin_sel);
      if (bus.done) begin saw_done = 1'b1; break; end
      if (bus.short_fail) begin saw_fail = 1'b1; break; end
      tick();
    end
  endtask

  initial begin
    reset          = 1'b1;
    bus.start      = 1'b0;
    bus.amount     = '0;
    bus.refill     = '0;
    bus.coin_ready = 1'b0;
    tick();
    tick();
    check("rst_valid", bus.coin_valid, 0);
    check("rst_sel", bus.coin_sel, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_done", bus.done, 0);
    check("rst_fail", bus.short_fail, 0);
    check("rst_rem", bus.remaining, 0);
    check("rst_empty", bus.stock_empty, 0);
    check("rst_stock2", dut.stock[2], 8);
    reset = 1'b0;
    tick();

    // amount 8 -> 500, 200, 100
    bus.coin_ready = 1'b1;
    pay(4'd8);
    check("t1_ncoins", coins.size(), 3);
    if (coins.size() == 3) begin
      check("t1_c0", coins[0], 4'b0100);
      check("t1_c1", coins[1], 4'b0010);
      check("t1_c2", coins[2], 4'b0001);
    end
    check("t1_done", saw_done, 1);
    check("t1_rem", bus.remaining, 0);
    check("t1_s1000", dut.stock[3], 8);
    check("t1_s500", dut.stock[2], 7);
    check("t1_s200", dut.stock[1], 7);
    check("t1_s100", dut.stock[0], 7);
    tick();
    check("t1_idle", bus.busy, 0);

    // amount 10 with stalled hopper; a second start during the stall is ignored
    bus.coin_ready = 1'b0;
    bus.start  = 1'b1;
    bus.amount = 4'd10;
    tick();
    bus.start = 1'b0;
    check("t2_lat_pick", bus.coin_valid, 0);
    tick();
    for (int i = 0; i < 5; i++) begin
      check("t2_valid", bus.coin_valid, 1);
      check("t2_sel", bus.coin_sel, 4'b1000);
      bus.start  = (i == 1);
      bus.amount = 4'd3;
      tick();
    end
    bus.start = 1'b0;
    check("t2_rem_hold", bus.remaining, 10);
    bus.coin_ready = 1'b1;
    tick();
    check("t2_done", bus.done, 1);
    check("t2_valid_off", bus.coin_valid, 0);
    check("t2_rem", bus.remaining, 0);
    check("t2_s1000", dut.stock[3], 7);
    tick();
    check("t2_idle", bus.busy, 0);

    // drain 100 stock, then amount 6 pays 500 and falls short
    for (int i = 0; i < 7; i++) begin
      pay(4'd1);
      tick();
    end
    check("t3_s100", dut.stock[0], 0);
    check("t3_empty", bus.stock_empty, 4'b0001);
    pay(4'd6);
    check("t3_ncoins", coins.size(), 1);
    if (coins.size() == 1) check("t3_c0", coins[0], 4'b0100);
    check("t3_fail", saw_fail, 1);
    check("t3_rem", bus.remaining, 1);
    tick();
    check("t3_idle", bus.busy, 0);
    check("t3_rem_hold", bus.remaining, 1);
    check("t3_s500", dut.stock[2], 6);

    // rejects: over max keeps remaining, zero pays nothing
    pay(4'd11);
    check("t4_big_fail", saw_fail, 1);
    check("t4_big_ncoins", coins.size(), 0);
    check("t4_big_rem", bus.remaining, 1);
    tick();
    pay(4'd0);
    check("t4_zero_done", saw_done, 1);
    check("t4_zero_ncoins", coins.size(), 0);
    tick();

    // refill on 500 during a 500 handshake nets to zero
    bus.coin_ready = 1'b0;
    bus.start  = 1'b1;
    bus.amount = 4'd5;
    tick();
    bus.start = 1'b0;
    tick();
    check("t5_sel", bus.coin_sel, 4'b0100);
    bus.coin_ready = 1'b1;
    bus.refill     = 4'b0100;
    tick();
    bus.refill = 4'b0000;
    check("t5_done", bus.done, 1);
    check("t5_s500", dut.stock[2], 6);
    tick();

    // refill saturation at 15, and refill clears empty
    bus.refill = 4'b1000;
    for (int i = 0; i < 10; i++) tick();
    bus.refill = 4'b0000;
    check("t5_sat", dut.stock[3], 15);
    bus.refill = 4'b0001;
    tick();
    bus.refill = 4'b0000;
    check("t5_s100", dut.stock[0], 1);
    check("t5_empty", bus.stock_empty, 4'b0000);

    // reset in the middle of an offer
    bus.coin_ready = 1'b0;
    bus.start  = 1'b1;
    bus.amount = 4'd10;
    tick();
    bus.start = 1'b0;
    tick();
    check("t6_offer", bus.coin_valid, 1);
    #2;
    reset = 1'b1;
    #1;
    check("t6_valid", bus.coin_valid, 0);
    check("t6_sel", bus.coin_sel, 0);
    check("t6_busy", bus.busy, 0);
    check("t6_rem", bus.remaining, 0);
    check("t6_s1000", dut.stock[3], 8);
    check("t6_s100", dut.stock[0], 8);
    tick();
    reset = 1'b0;
    tick();
    bus.coin_ready = 1'b1;
    pay(4'd2);
    check("t6_after_ncoins", coins.size(), 1);
    if (coins.size() == 1) check("t6_after_c0", coins[0], 4'b0010);
    check("t6_after_done", saw_done, 1);
    tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
